// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge and exception freeze/flush sequencer for the 5-stage pipeline.
// Optional stall watchdog enabled by defining PIPE_CTRL_WDT_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VEC      = 32'hBFC0_0380,
  parameter int unsigned WDT_CYCLES   = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        exc_valid_i,
  input  logic        exc_eret_i,
  input  logic [31:0] exc_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o,
  output logic        wdt_timeout_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEND  = 3'd1,
    FLUSH = 3'd2
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("pipe_ctrl: FLUSH_CYCLES must be in 1..7");
  end
  if (WDT_CYCLES < 1 || WDT_CYCLES > 1023) begin : g_bad_wdt_cycles
    $error("pipe_ctrl: WDT_CYCLES must be in 1..1023");
  end

  state_t      state, state_next;
  logic [2:0]  flush_cnt, flush_cnt_next;
  logic [31:0] target;
  logic        accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      flush_cnt <= 3'd0;
      target    <= 32'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      if (accept) begin
        target <= exc_eret_i ? exc_epc_i : EXC_VEC;
      end
    end
  end

  // Stall vector is gated by reset so an asserted reset masks live requests.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    accept         = 1'b0;
    stall_o        = 6'b000000;
    flush_o        = 1'b0;
    busy_o         = 1'b0;

    case (state)
      IDLE: begin
        if (exc_valid_i) begin
          accept         = 1'b1;
          stall_o        = 6'b111111;
          flush_cnt_next = 3'd0;
          state_next     = stallreq_mem_i ? PEND : FLUSH;
        end else if (stallreq_mem_i) begin
          stall_o = 6'b011111;
        end else if (stallreq_ex_i) begin
          stall_o = 6'b001111;
        end else if (stallreq_id_i) begin
          stall_o = 6'b000111;
        end else if (stallreq_if_i) begin
          stall_o = 6'b000011;
        end
      end
      PEND: begin
        busy_o  = 1'b1;
        stall_o = 6'b111111;
        if (!stallreq_mem_i) begin
          state_next     = FLUSH;
          flush_cnt_next = 3'd0;
        end
      end
      FLUSH: begin
        busy_o  = 1'b1;
        flush_o = 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          state_next     = IDLE;
          flush_cnt_next = 3'd0;
        end else begin
          flush_cnt_next = flush_cnt + 3'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        flush_cnt_next = 3'd0;
      end
    endcase

    if (!rst_ni) begin
      stall_o = 6'b000000;
    end
  end

  assign new_pc_o = target;

`ifdef PIPE_CTRL_WDT_EN
  localparam logic [9:0] WDT_LIMIT = 10'(WDT_CYCLES);

  logic [9:0] wdt_cnt;
  logic       wdt_flag;

  // Flag sets on the same edge the counter reaches the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdt_cnt  <= 10'd0;
      wdt_flag <= 1'b0;
    end else if (stall_o != 6'b000000) begin
      if (wdt_cnt != WDT_LIMIT) begin
        wdt_cnt <= wdt_cnt + 10'd1;
      end
      if (wdt_cnt >= WDT_LIMIT - 10'd1) begin
        wdt_flag <= 1'b1;
      end
    end else begin
      wdt_cnt <= 10'd0;
    end
  end

  assign wdt_timeout_o = wdt_flag;
`else
  assign wdt_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model.
// Models the watchdog only when PIPE_CTRL_WDT_EN is defined.
module tb_pipe_ctrl;

  localparam int unsigned FC  = 3;
  localparam int unsigned WDT = 16;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        exc_valid_i, exc_eret_i;
  logic [31:0] exc_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic        wdt_timeout_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  bit          m_frozen;
  int          m_flush_left;
  logic [31:0] m_target;
  int          m_run;
  bit          m_wdt;

  pipe_ctrl #(
    .FLUSH_CYCLES(FC),
    .EXC_VEC     (VEC),
    .WDT_CYCLES  (WDT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stallreq_if_i (stallreq_if_i),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .stallreq_mem_i(stallreq_mem_i),
    .exc_valid_i   (exc_valid_i),
    .exc_eret_i    (exc_eret_i),
    .exc_epc_i     (exc_epc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .busy_o        (busy_o),
    .wdt_timeout_o (wdt_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_frozen     = 1'b0;
    m_flush_left = 0;
    m_target     = 32'd0;
    m_run        = 0;
    m_wdt        = 1'b0;
  endtask

  // Highest requesting stage i (if=0..mem=3) freezes the PC plus i+1 pipeline registers.
  function automatic logic [5:0] mergedStall(input logic [3:0] req);
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) return 6'((7'd1 << (i + 2)) - 7'd1);
    end
    return 6'b000000;
  endfunction

  // req = {mem, ex, id, if}; called at a negedge, returns at the next negedge.
  task automatic applyStimulus(input logic [3:0] req, input logic exc, input logic eret, input logic [31:0] epc);
    logic [5:0] exp_stall;
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req;
    exc_valid_i = exc;
    exc_eret_i  = eret;
    exc_epc_i   = epc;
    #2;
    if (m_flush_left > 0)       exp_stall = 6'b000000;
    else if (m_frozen || exc)   exp_stall = 6'b111111;
    else                        exp_stall = mergedStall(req);
    checkOutput("stall", 32'(stall_o), 32'(exp_stall));
    checkOutput("flush", 32'(flush_o), 32'(m_flush_left > 0));
    checkOutput("busy", 32'(busy_o), 32'(m_flush_left > 0 || m_frozen));
    checkOutput("new_pc", new_pc_o, m_target);
    checkOutput("wdt", 32'(wdt_timeout_o), 32'(m_wdt));
    @(posedge clk_i);
`ifdef PIPE_CTRL_WDT_EN
    if (exp_stall != 6'b000000) begin
      if (m_run < 1023) m_run++;
      if (m_run >= WDT) m_wdt = 1'b1;
    end else begin
      m_run = 0;
    end
`endif
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_frozen) begin
      if (!req[3]) begin
        m_frozen     = 1'b0;
        m_flush_left = FC;
      end
    end else if (exc) begin
      m_target = eret ? epc : VEC;
      if (req[3]) m_frozen = 1'b1;
      else        m_flush_left = FC;
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    stallreq_if_i = 1'b0; stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0; stallreq_mem_i = 1'b1;
    exc_valid_i = 1'b1; exc_eret_i = 1'b0; exc_epc_i = 32'd0;
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    checkOutput("reset_flush", 32'(flush_o), 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_new_pc", new_pc_o, 32'd0);
    checkOutput("reset_wdt", 32'(wdt_timeout_o), 32'd0);
    stallreq_mem_i = 1'b0;
    exc_valid_i    = 1'b0;
    rst_ni         = 1'b1;

    // Stall priority: ex over id, then id alone
    applyStimulus(4'b0110, 1'b0, 1'b0, 32'd0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 32'd0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 32'd0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 32'd0);
    idle(1);

    // Plain exception together with a non-MEM stall request
    applyStimulus(4'b0100, 1'b1, 1'b0, 32'h1234_5678);
    idle(FC + 2);

    // ERET behind a dcache miss; an extra exception during PEND is ignored
    applyStimulus(4'b1000, 1'b1, 1'b1, 32'h8000_1234);
    applyStimulus(4'b1000, 1'b0, 1'b0, 32'd0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(4'b1000, 1'b0, 1'b0, 32'd0);
    idle(FC + 2);

    // Second pulse during FLUSH is ignored; a new one right after FLUSH is accepted
    applyStimulus(4'b0000, 1'b1, 1'b1, 32'h0000_4000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'd0);
    applyStimulus(4'b1010, 1'b1, 1'b1, 32'h0000_5000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 32'd0);
    idle(FC + 1);

    // Reset in the first FLUSH cycle aborts the flush
    applyStimulus(4'b0000, 1'b1, 1'b1, 32'h0000_6000);
    stallreq_mem_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("midflush_rst_flush", 32'(flush_o), 32'd0);
    checkOutput("midflush_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("midflush_rst_stall", 32'(stall_o), 32'd0);
    checkOutput("midflush_rst_new_pc", new_pc_o, 32'd0);
    modelReset();
    @(negedge clk_i);
    stallreq_mem_i = 1'b0;
    rst_ni = 1'b1;
    idle(FC + 1);

    // Long fetch stall for the watchdog
    for (int i = 0; i < WDT + 4; i++) applyStimulus(4'b0001, 1'b0, 1'b0, 32'd0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] req;
      req[0] = ($urandom_range(0, 2) == 0);
      req[1] = ($urandom_range(0, 3) == 0);
      req[2] = ($urandom_range(0, 3) == 0);
      req[3] = ($urandom_range(0, 2) == 0);
      applyStimulus(req, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
